// File: rtl/mod_arith_pkg.sv
// Shared opcode definitions for the modular arithmetic unit and its clients.
package mod_arith_pkg;

  // Requester opcode: one bit per requester on the req_op bus
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/mod_add.sv
// Modular adder: C = (A + B) mod modulus, for operands already below modulus.
module mod_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] C
);

  logic [WIDTH:0] w_sum;
  logic           w_wrap;

  // Add with one guard bit so the carry is kept, then subtract q once if the sum reached it
  always_comb begin
    w_sum  = {1'b0, A} + {1'b0, B};
    w_wrap = (w_sum >= {1'b0, modulus});
    C      = w_wrap ? WIDTH'(w_sum - {1'b0, modulus}) : w_sum[WIDTH-1:0];
  end

endmodule

// File: rtl/mod_sub.sv
// Modular subtractor: C = (A - B) mod modulus, for operands already below modulus.
module mod_sub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] C
);

  logic [WIDTH:0] w_diff;
  logic           w_neg;

  // The guard bit of the difference acts as the sign; add q back once when it went negative
  always_comb begin
    w_diff = {1'b0, A} - {1'b0, B};
    w_neg  = w_diff[WIDTH];
    C      = w_neg ? WIDTH'(w_diff[WIDTH-1:0] + modulus) : w_diff[WIDTH-1:0];
  end

endmodule

// File: rtl/mod_arith_arbiter.sv
// Round-robin arbiter in front of a two-stage modular add/subtract pipeline.
// S1 holds the granted operands, S2 holds the result; both advance together
// whenever the response slot is free or being drained this cycle.
module mod_arith_arbiter
  import mod_arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      modulus,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy
);

  logic             r_s1Valid;
  logic [IDW-1:0]   r_s1Id;
  op_e              r_s1Op;
  logic [WIDTH-1:0] r_s1A;
  logic [WIDTH-1:0] r_s1B;

  logic             r_s2Valid;
  logic [IDW-1:0]   r_s2Id;
  logic [WIDTH-1:0] r_s2Data;

  logic [IDW-1:0]   r_ptr;

  logic             w_advance;
  logic             w_grantValid;
  logic [IDW-1:0]   w_grantIdx;
  logic             w_accept;
  logic [IDW-1:0]   w_ptrNext;
  logic [WIDTH-1:0] w_addC;
  logic [WIDTH-1:0] w_subC;
  logic [WIDTH-1:0] w_result;

  assign w_advance = !r_s2Valid || rsp_ready;
  assign w_accept  = w_grantValid && w_advance;
  assign w_ptrNext = (w_grantIdx == IDW'(NREQ - 1)) ? '0 : w_grantIdx + 1'b1;

  // Round-robin search starting at the pointer; walking offsets downwards lets the
  // smallest cyclic offset with a valid request overwrite the others
  always_comb begin
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[IDW'((int'(r_ptr) + k) % NREQ)]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = IDW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  // One-hot accept back to the granted requester; suppressed while reset is held
  always_comb begin
    req_ready = '0;
    if (w_accept && !rst) begin
      req_ready[w_grantIdx] = 1'b1;
    end
  end

  mod_add #(.WIDTH(WIDTH)) u_add (
    .A       (r_s1A),
    .B       (r_s1B),
    .modulus (modulus),
    .C       (w_addC)
  );

  mod_sub #(.WIDTH(WIDTH)) u_sub (
    .A       (r_s1A),
    .B       (r_s1B),
    .modulus (modulus),
    .C       (w_subC)
  );

  assign w_result = (r_s1Op == OP_SUB) ? w_subC : w_addC;

  // Pipeline and pointer state; nothing moves while the response slot is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Id    <= '0;
      r_s1Op    <= OP_ADD;
      r_s1A     <= '0;
      r_s1B     <= '0;
      r_s2Valid <= 1'b0;
      r_s2Id    <= '0;
      r_s2Data  <= '0;
      r_ptr     <= '0;
    end else if (w_advance) begin
      r_s1Valid <= w_accept;
      if (w_accept) begin
        r_s1Id <= w_grantIdx;
        r_s1Op <= op_e'(req_op[w_grantIdx]);
        r_s1A  <= req_a[w_grantIdx*WIDTH +: WIDTH];
        r_s1B  <= req_b[w_grantIdx*WIDTH +: WIDTH];
        r_ptr  <= w_ptrNext;
      end
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Id   <= r_s1Id;
        r_s2Data <= w_result;
      end
    end
  end

  assign rsp_valid = r_s2Valid;
  assign rsp_id    = r_s2Id;
  assign rsp_data  = r_s2Data;
  assign busy      = r_s1Valid || r_s2Valid;

endmodule

// File: tb/tb_mod_arith_arbiter.sv
// Self-checking bench for mod_arith_arbiter with q = 17, WIDTH = 32, NREQ = 4.
module tb_mod_arith_arbiter;

   localparam int WIDTH = 32;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;
   localparam longint Q = 17;

   logic                  clk;
   logic                  rst;
   logic [WIDTH-1:0]      modulus;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       req_op;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_data;
   logic                  busy;

   int errors = 0;
   int checks = 0;

   logic [WIDTH-1:0] aArr [NREQ];
   logic [WIDTH-1:0] bArr [NREQ];
   logic             opArr [NREQ];

   typedef struct {
      int               id;
      logic [WIDTH-1:0] res;
      int               moves;
   } entry_t;

   entry_t inFlight[$];
   int     modelPtr = 0;

   mod_arith_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .modulus   (modulus),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference arithmetic straight from the modular definitions
   function automatic logic [WIDTH-1:0] modelResult(input logic op, input longint a, input longint b);
      if (!op) return WIDTH'((a + b) % Q);
      return WIDTH'((a - b + Q) % Q);
   endfunction

   // One counted comparison
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Load one requester's operation into the stimulus arrays
   task automatic setReq(input int i, input logic op, input int a, input int b);
      opArr[i] = op;
      aArr[i]  = WIDTH'(a);
      bArr[i]  = WIDTH'(b);
   endtask

   // Drive one cycle, check outputs against the model, then advance the model past the edge
   task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic rr, input logic rstIn);
      bit               headVisible;
      bit               advance;
      int               grant;
      logic [NREQ-1:0]  expReady;
      entry_t           e;
      rst       = rstIn;
      req_valid = valid;
      rsp_ready = rr;
      for (int i = 0; i < NREQ; i++) begin
         req_op[i]               = opArr[i];
         req_a[i*WIDTH +: WIDTH] = aArr[i];
         req_b[i*WIDTH +: WIDTH] = bArr[i];
      end
      #1;
      headVisible = (inFlight.size() > 0) && (inFlight[0].moves >= 1);
      advance     = !headVisible || rr;
      grant       = -1;
      if (!rstIn && advance) begin
         for (int k = 0; k < NREQ; k++) begin
            if (grant < 0 && valid[(modelPtr + k) % NREQ]) grant = (modelPtr + k) % NREQ;
         end
      end
      expReady = (grant >= 0) ? NREQ'(1 << grant) : '0;
      checkOutput("req_ready", 64'(req_ready), 64'(expReady));
      checkOutput("rsp_valid", 64'(rsp_valid), 64'(headVisible));
      if (headVisible) begin
         checkOutput("rsp_id", 64'(rsp_id), 64'(inFlight[0].id));
         checkOutput("rsp_data", 64'(rsp_data), 64'(inFlight[0].res));
      end
      checkOutput("busy", 64'(busy), 64'(inFlight.size() > 0));
      @(posedge clk);
      if (rstIn) begin
         inFlight.delete();
         modelPtr = 0;
      end else if (advance) begin
         if (headVisible && rr) void'(inFlight.pop_front());
         foreach (inFlight[i]) inFlight[i].moves++;
         if (grant >= 0) begin
            e.id    = grant;
            e.res   = modelResult(opArr[grant], longint'(aArr[grant]), longint'(bArr[grant]));
            e.moves = 0;
            inFlight.push_back(e);
            modelPtr = (grant + 1) % NREQ;
         end
      end
      @(negedge clk);
   endtask

   // Directed scenarios followed by a randomized soak, all in one linear sequence
   initial begin
      modulus   = WIDTH'(Q);
      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b1;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      for (int i = 0; i < NREQ; i++) setReq(i, 1'b0, 0, 0);
      @(negedge clk);

      // Reset state
      applyStimulus(4'b0000, 1'b1, 1'b1);
      applyStimulus(4'b0000, 1'b1, 1'b1);
      checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("reset_rsp_data", 64'(rsp_data), 64'd0);
      checkOutput("reset_rsp_id", 64'(rsp_id), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);

      // All four requesters held valid: round-robin from pointer 0
      for (int i = 0; i < NREQ; i++) setReq(i, 1'(i % 2), (i * 3) % 17, (i * 7 + 2) % 17);
      for (int c = 0; c < 8; c++) applyStimulus(4'b1111, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) applyStimulus(4'b0000, 1'b1, 1'b0);

      // Requester 0 add 9 + 12 -> 4
      setReq(0, 1'b0, 9, 12);
      applyStimulus(4'b0001, 1'b1, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      checkOutput("add_9_12_data", 64'(rsp_data), 64'd4);
      checkOutput("add_9_12_id", 64'(rsp_id), 64'd0);
      applyStimulus(4'b0000, 1'b1, 1'b0);

      // Requester 2 back-to-back subtracts: 3 - 5 -> 15, 5 - 5 -> 0
      setReq(2, 1'b1, 3, 5);
      applyStimulus(4'b0100, 1'b1, 1'b0);
      setReq(2, 1'b1, 5, 5);
      applyStimulus(4'b0100, 1'b1, 1'b0);
      checkOutput("sub_3_5_data", 64'(rsp_data), 64'd15);
      checkOutput("sub_3_5_id", 64'(rsp_id), 64'd2);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      checkOutput("sub_5_5_data", 64'(rsp_data), 64'd0);
      checkOutput("sub_5_5_id", 64'(rsp_id), 64'd2);
      applyStimulus(4'b0000, 1'b1, 1'b0);

      // Wrap boundaries: 16 + 16 -> 15, 0 - 16 -> 1
      setReq(1, 1'b0, 16, 16);
      applyStimulus(4'b0010, 1'b1, 1'b0);
      setReq(3, 1'b1, 0, 16);
      applyStimulus(4'b1000, 1'b1, 1'b0);
      checkOutput("add_16_16_data", 64'(rsp_data), 64'd15);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      checkOutput("sub_0_16_data", 64'(rsp_data), 64'd1);
      applyStimulus(4'b0000, 1'b1, 1'b0);

      // Fill the pipeline, stall the response for three cycles, then drain
      for (int i = 0; i < NREQ; i++) setReq(i, 1'b0, i + 10, i + 4);
      applyStimulus(4'b1111, 1'b0, 1'b0);
      applyStimulus(4'b1111, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) applyStimulus(4'b1111, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) applyStimulus(4'b1111, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) applyStimulus(4'b0000, 1'b1, 1'b0);

      // Randomized traffic with occasional stalls and resets
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            setReq(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 16)), int'($urandom_range(0, 16)));
         end
         applyStimulus(NREQ'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 2));
      end
      for (int c = 0; c < 3; c++) applyStimulus(4'b0000, 1'b1, 1'b0);

      // Reset with both stages occupied, then a requester-3-only operation
      applyStimulus(4'b1111, 1'b0, 1'b0);
      applyStimulus(4'b1111, 1'b0, 1'b0);
      checkOutput("full_before_reset", 64'({rsp_valid, busy}), 64'b11);
      applyStimulus(4'b0000, 1'b0, 1'b1);
      checkOutput("post_reset_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("post_reset_busy", 64'(busy), 64'd0);
      setReq(3, 1'b0, 1, 2);
      applyStimulus(4'b1000, 1'b1, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      checkOutput("req3_id", 64'(rsp_id), 64'd3);
      checkOutput("req3_data", 64'(rsp_data), 64'd3);
      for (int c = 0; c < 3; c++) applyStimulus(4'b0000, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mod_arith_arbiter.md
MOD_ARITH_ARBITER -- requirements
Module: mod_arith_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/modulus/result width in bits.
REQ-002 Parameter NREQ, default 4, number of requesters sharing the unit (2..8).
REQ-003 Parameter IDW, default 2, requester-id width, SHALL equal ceil(log2(NREQ)).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 modulus  input  WIDTH  shared modulus q, static while busy is high.
REQ-007 req_valid  input  NREQ  per-requester operation valid.
REQ-008 req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-009 req_op  input  NREQ  per-requester opcode: 0 = modular add, 1 = modular subtract.
REQ-010 req_a  input  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
REQ-011 req_b  input  NREQ*WIDTH  operand B, same packing as req_a.
REQ-012 rsp_valid  output  1  result valid.
REQ-013 rsp_ready  input  1  downstream accepts result.
REQ-014 rsp_id  output  IDW  index of requester that issued the result.
REQ-015 rsp_data  output  WIDTH  result value.
REQ-016 busy  output  1  high while any pipeline stage holds an operation.

Function
REQ-017 Handshake on request i SHALL complete in a cycle where req_valid[i] and req_ready[i] are both high; on response when rsp_valid and rsp_ready are both high.
REQ-018 Pipeline SHALL be two registered stages, S1 (operands, op, id) and S2 (result, id); advance = !S2.valid || rsp_ready, and both stages move only on advance.
REQ-019 req_ready[i] SHALL be high only when advance is high and i is the granted requester; req_ready SHALL be combinational from req_valid, pointer and advance, never from req_op/req_a/req_b.
REQ-020 Arbitration SHALL be round-robin: grant lowest index j >= ptr (cyclic, wrapping NREQ-1 -> 0) with req_valid[j] high; no grant if no req_valid.
REQ-021 ptr SHALL reset to 0 and, on each accepted request from j, update to (j+1) mod NREQ; unchanged otherwise.
REQ-022 Latency: request accepted at edge t SHALL appear on rsp_valid/rsp_data/rsp_id after edge t+1 with no stall; throughput one op per cycle.
REQ-023 Add: sum = A+B in WIDTH+1 bits; result = sum-q if sum >= q, else sum.
REQ-024 Subtract: diff = A-B in WIDTH+1 bits signed; result = diff+q if diff < 0, else diff.
REQ-025 Operands SHALL be required < q; results for out-of-range operands are unspecified but SHALL NOT corrupt arbitration or handshake state.
REQ-026 While rsp_valid high and rsp_ready low, rsp_data/rsp_id SHALL hold stable and no request SHALL be accepted.
REQ-027 Simultaneous response handshake and new request in one cycle SHALL both complete (full throughput under rsp_ready high).
REQ-028 Results SHALL emerge in acceptance order; no operation dropped or duplicated.
REQ-029 busy = S1.valid || S2.valid.

Reset
REQ-030 On rst high at a clock edge: S1.valid, S2.valid, ptr cleared; rsp_valid = 0, rsp_data = 0, rsp_id = 0, busy = 0.
REQ-031 During rst cycle req_ready SHALL be all-zero; in-flight operations SHALL be discarded on reset mid-operation with no response emitted.
REQ-032 First grant after reset release SHALL use ptr = 0.

Structure
REQ-033 Opcode constants (OP_ADD = 0, OP_SUB = 1) SHALL live in a shared package mod_arith_pkg.
REQ-034 Subtract path SHALL instantiate existing mod_sub; add path SHALL be a new sub-module mod_add with matching ports (A, B, modulus, C); arbiter and pipeline control stay in the top.

Verification (q = 17, WIDTH = 32, NREQ = 4)
REQ-035 Req0 add A=9,B=12, rsp_ready=1 -> rsp_valid two cycles after accept, rsp_data=4, rsp_id=0.
REQ-036 Req2 sub A=3,B=5, then A=5,B=5 -> rsp_data=15 then 0, rsp_id=2 both, back-to-back cycles.
REQ-037 All four req_valid held high 8 cycles, rsp_ready=1 -> grants 0,1,2,3,0,1,2,3; rsp_id same order.
REQ-038 rsp_ready low 3 cycles with pipeline full -> req_ready all 0, rsp_data/rsp_id stable, no loss after rsp_ready returns.
REQ-039 Add A=16,B=16 and sub A=0,B=16 -> 15 and 1 (boundary of sum >= q and diff < 0).
REQ-040 Assert rst with both stages valid -> next cycle rsp_valid=0, busy=0, ptr=0; subsequent req3-only request granted and returns rsp_id=3.
